uart_rx_mmio: RTL and testbench
===============================

// Module: uart_rx_mmio
// PURPOSE
//  UART receiver (8 data bits, LSB first, 1 stop) with an RX FIFO and a CPU-facing MMIO read port.
//  Counterpart of the UART transmitter on cpu_top: drives serial input toward the CPU.
//  CPU polls STATUS or uses irq, then reads DATA to pop bytes.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        115200      line rate; DIV = CLK_FREQ/BAUD (integer, >= 4)
//  FIFO_DEPTH  4           RX FIFO entries; power of 2, >= 2
// PORTS
//  clk      in   1   system clock
//  rst      in   1   synchronous reset, active-high
//  rx       in   1   serial line, idle high, asynchronous
//  rd_en    in   1   MMIO read strobe, one cycle
//  addr     in   1   0 = DATA, 1 = STATUS
//  rd_data  out  32  read data, valid the cycle after rd_en
//  irq      out  1   high while FIFO non-empty
// BEHAVIOUR
//  Reset: rd_data=0, irq=0, FIFO empty, flags clear, FSM IDLE, synchronizer regs=1.
//  rx passes a 2-flop synchronizer; all FSM sampling uses the synchronized value.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: sync rx low -> START, baud counter cleared.
//   START: after DIV/2 cycles resample; low -> DATA, high -> IDLE (glitch, no flags).
//   DATA: sample every DIV cycles, 8 bits, shift in LSB first.
//   STOP: sample after DIV cycles; 1 -> push byte; 0 -> frame_err set, byte dropped. -> IDLE.
//  Push when FIFO full and no same-cycle pop: byte dropped, overrun set.
//  Push and pop same cycle: both happen; when full, pushed byte accepted, count unchanged.
//  DATA read: rd_data={24'b0, head byte}, pop if non-empty; empty -> rd_data=0, no pop.
//  STATUS read: rd_data={27'b0, parity_err, overrun, frame_err, full, nonempty};
//   sticky flags (parity_err, overrun, frame_err) clear after being read; an error
//   event in the same cycle as the STATUS read wins (flag stays set).
//  rd_data holds last value when rd_en low. irq = nonempty, combinational from count.
//  Read pointer/write pointer wrap modulo FIFO_DEPTH; count width log2(DEPTH)+1.
//  rst mid-frame: partial byte discarded, FSM IDLE next cycle, FIFO and flags cleared.
//  Line held low (break): one frame_err per 10-bit time, then waits in IDLE until rx high
//   before accepting a new start edge.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: even parity bit after data; PARITY state samples it;
//   mismatch sets parity_err and drops the byte (stop bit still checked).
//  Undefined: 8N1, no PARITY state, STATUS bit 4 reads 0.
// TESTING (CLK_FREQ=16, BAUD=1 -> DIV=16)
//  rx frame 0x55 -> irq rises after stop sample; DATA read returns 0x55; irq falls.
//  3 frames 0x01,0x02,0x03 back-to-back -> DATA reads return them in order, STATUS=0 after.
//  5 frames into DEPTH=4 unread -> STATUS=0b01011 (overrun,full,nonempty); bytes 1-4 intact.
//  stop bit forced 0 on 0xA5 -> FIFO stays empty, STATUS=0b00100, reads 0 on 2nd STATUS read.
//  8-cycle low glitch on idle rx -> no byte, no flags, FSM back in IDLE.
//  rst asserted mid-DATA of 0x3C, then clean 0xC3 -> only 0xC3 received.
//  (PARITY_EN) 0x07 with parity bit 0 -> dropped, parity_err set; with 1 -> accepted.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// UART receiver (8 data bits, LSB first, 1 stop) with RX FIFO and MMIO read port.
// Define UART_RX_PARITY_EN for an even parity bit after the data bits.
module uart_rx_mmio #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_en,
  input  logic        addr,
  output logic [31:0] rd_data,
  output logic        irq
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic          rx_s1, rx_s2;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          armed;
  logic          push_req, fe_evt;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, pe_evt, pe_flag;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // armed gates new start edges: after a break the line must return high first
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      armed    <= 1'b1;
      push_req <= 1'b0;
      fe_evt   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
      pe_evt   <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      fe_evt   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_evt   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_s2) armed <= 1'b1;
          else if (armed) begin
            state <= START;
            cnt   <= '0;
            armed <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else cnt <= cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= rx_s2 ^ (^shreg);
            pe_evt  <= rx_s2 ^ (^shreg);
            state   <= STOP;
          end else cnt <= cnt + 1'b1;
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s2) fe_evt <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (!par_bad) push_req <= 1'b1;
`else
            else push_req <= 1'b1;
`endif
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO: shreg stays stable until the next frame's data, so it is written directly
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, nonempty, pop, push_ok, ovr_evt, rd_status;
  logic          fe_flag, ovr_flag, pe_bit;

  always_comb begin
    full      = (count == FULL_CNT);
    nonempty  = (count != '0);
    pop       = rd_en && !addr && nonempty;
    rd_status = rd_en && addr;
    push_ok   = push_req && (!full || pop);
    ovr_evt   = push_req && full && !pop;
  end

`ifdef UART_RX_PARITY_EN
  assign pe_bit = pe_flag;
`else
  assign pe_bit = 1'b0;
`endif
  assign irq = nonempty;

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= shreg;
  end

  // Sticky flags: a same-cycle event beats the clear-on-STATUS-read
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fe_flag  <= 1'b0;
      ovr_flag <= 1'b0;
      rd_data  <= '0;
`ifdef UART_RX_PARITY_EN
      pe_flag  <= 1'b0;
`endif
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      fe_flag  <= fe_evt  | (fe_flag  & ~rd_status);
      ovr_flag <= ovr_evt | (ovr_flag & ~rd_status);
`ifdef UART_RX_PARITY_EN
      pe_flag  <= pe_evt  | (pe_flag  & ~rd_status);
`endif
      if (rd_en) begin
        if (addr)     rd_data <= {27'b0, pe_bit, ovr_flag, fe_flag, full, nonempty};
        else if (pop) rd_data <= {24'b0, mem[rd_ptr]};
        else          rd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at DIV=16 (CLK_FREQ=16, BAUD=1), FIFO_DEPTH=4.
module tb_uart_rx_mmio;
  logic        clk = 1'b0;
  logic        rst, rx, rd_en, addr;
  logic [31:0] rd_data;
  logic        irq;
  logic [31:0] d;
  int          checks = 0;
  int          failures = 0;

  uart_rx_mmio #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .addr(addr),
    .rd_data(rd_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(^b);
`endif
    bit_time(stop_v);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_badpar(input logic [7:0] b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(~^b);
    bit_time(1'b1);
    rx = 1'b1;
  endtask
`endif

  task automatic rd(input logic a, output logic [31:0] v);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
    v     = rd_data;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; addr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rd(1'b1, d); chk("reset_status", d, 32'h0);

    // single frame, irq follows FIFO occupancy
    chk("irq_before", {31'b0, irq}, 32'h0);
    send(8'h55, 1'b1);
    chk("irq_after_stop", {31'b0, irq}, 32'h1);
    rd(1'b0, d); chk("data_55", d, 32'h55);
    chk("irq_after_pop", {31'b0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    chk("rd_data_hold", rd_data, 32'h55);
    rd(1'b0, d); chk("data_empty", d, 32'h0);

    // back-to-back frames in order
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1);
    rd(1'b0, d); chk("b2b_0", d, 32'h01);
    rd(1'b0, d); chk("b2b_1", d, 32'h02);
    rd(1'b0, d); chk("b2b_2", d, 32'h03);
    rd(1'b1, d); chk("b2b_status", d, 32'h0);

    // overrun: fifth frame dropped
    send(8'h10, 1'b1); send(8'h20, 1'b1); send(8'h30, 1'b1);
    send(8'h40, 1'b1); send(8'h50, 1'b1);
    rd(1'b1, d); chk("ovr_status", d, 32'h0B);
    rd(1'b0, d); chk("ovr_d0", d, 32'h10);
    rd(1'b0, d); chk("ovr_d1", d, 32'h20);
    rd(1'b0, d); chk("ovr_d2", d, 32'h30);
    rd(1'b0, d); chk("ovr_d3", d, 32'h40);
    rd(1'b1, d); chk("ovr_cleared", d, 32'h0);

    // framing error
    send(8'hA5, 1'b0);
    repeat (4) @(negedge clk);
    chk("fe_irq", {31'b0, irq}, 32'h0);
    rd(1'b1, d); chk("fe_status", d, 32'h04);
    rd(1'b1, d); chk("fe_cleared", d, 32'h0);
    rd(1'b0, d); chk("fe_data_empty", d, 32'h0);

    // 8-cycle glitch is rejected, receiver still usable afterwards
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_irq", {31'b0, irq}, 32'h0);
    rd(1'b1, d); chk("glitch_status", d, 32'h0);
    send(8'h5A, 1'b1);
    rd(1'b0, d); chk("glitch_then_5a", d, 32'h5A);

    // reset mid-DATA of 0x3C, then a clean 0xC3
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(d[0] ^ d[0] ^ (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0);
    rst = 1'b1; rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    chk("midrst_rd_data", rd_data, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(8'hC3, 1'b1);
    rd(1'b1, d); chk("midrst_status", d, 32'h01);
    rd(1'b0, d); chk("midrst_c3", d, 32'hC3);
    rd(1'b1, d); chk("midrst_empty", d, 32'h0);

`ifdef UART_RX_PARITY_EN
    send_badpar(8'h07);
    rd(1'b1, d); chk("par_bad_status", d, 32'h10);
    send(8'h07, 1'b1);
    rd(1'b0, d); chk("par_good_07", d, 32'h07);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
